kamacore_muldiv_seq: RTL

Iterative multiply/divide sequencer for the kamacore execute stage, implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It accepts one operation from the ID/EX boundary and runs a shared radix-2 shift/add-subtract datapath for up to 32 iterations. While the operation runs it holds the pipeline with a stall signal, then presents the result for one cycle so the EX/MEM buffer can capture it in place of the ALU result.

---
 rtl/kamacore_muldiv_seq.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/kamacore_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: radix-2 shift-add multiply, restoring divide, pipeline stall.
// Optional build macro KAMACORE_FAST_MUL_EN swaps the shift-add multiply for a single-cycle 33x33 multiplier.
module kamacore_muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      result_rd
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [2:0] F_MUL    = 3'd0;
  localparam logic [2:0] F_MULH   = 3'd1;
  localparam logic [2:0] F_MULHSU = 3'd2;
  localparam logic [2:0] F_DIV    = 3'd4;
  localparam logic [2:0] F_REM    = 3'd6;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state_q;
  logic [4:0]          cnt_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [XLEN-1:0]     opd_q;
  logic [2:0]          funct3_q;
  logic [4:0]          rd_q;
  logic                neg_q;
  logic                busy_q;
  logic                done_q;
  logic [XLEN-1:0]     result_q;
  logic [4:0]          resultRd_q;

  logic                aSigned;
  logic                bSigned;
  logic                aNeg;
  logic                bNeg;
  logic [XLEN-1:0]     aMag;
  logic [XLEN-1:0]     bMag;
  logic                resNeg_d;
  logic                divZero;
  logic                divOvf;
  logic [XLEN-1:0]     special_d;

  // Operand conditioning at accept time: magnitudes, result sign and the two divide corner cases.
  always_comb begin
    aSigned   = (funct3 == F_MULH) || (funct3 == F_MULHSU) || (funct3 == F_DIV) || (funct3 == F_REM);
    bSigned   = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);
    aNeg      = aSigned && op_a[XLEN-1];
    bNeg      = bSigned && op_b[XLEN-1];
    aMag      = aNeg ? -op_a : op_a;
    bMag      = bNeg ? -op_b : op_b;
    resNeg_d  = (funct3 == F_REM) ? aNeg : (aNeg ^ bNeg);
    divZero   = (op_b == '0);
    divOvf    = bSigned && funct3[2] && (op_a == MOST_NEG) && (op_b == '1);
    if (divZero)
      special_d = funct3[1] ? op_a : '1;
    else
      special_d = funct3[1] ? '0 : MOST_NEG;
  end

  logic [XLEN:0]       mulSum;
  logic [XLEN:0]       divDiff;
  logic [2*XLEN-1:0]   step_d;
  logic [XLEN-1:0]     mulHiNeg;
  logic [XLEN-1:0]     divRaw;
  logic [XLEN-1:0]     final_d;

  // One shared iteration step; the final sign fix-up is folded into the last iteration's write.
  always_comb begin
    mulSum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opd_q};
    divDiff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opd_q};
    if (state_q == S_MUL)
      step_d = acc_q[0] ? {mulSum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
    else if (!divDiff[XLEN])
      step_d = {divDiff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else
      step_d = {acc_q[2*XLEN-2:0], 1'b0};
    // High half of the negated 64-bit product: borrow only propagates up when the low half is zero.
    mulHiNeg = ~step_d[2*XLEN-1:XLEN] + {{(XLEN-1){1'b0}}, (step_d[XLEN-1:0] == '0)};
    divRaw   = funct3_q[1] ? step_d[2*XLEN-1:XLEN] : step_d[XLEN-1:0];
    if (!funct3_q[2])
      final_d = (funct3_q == F_MUL) ? step_d[XLEN-1:0]
                                    : (neg_q ? mulHiNeg : step_d[2*XLEN-1:XLEN]);
    else
      final_d = neg_q ? -divRaw : divRaw;
  end

`ifdef KAMACORE_FAST_MUL_EN
  logic signed [XLEN:0]     fastA;
  logic signed [XLEN:0]     fastB;
  logic signed [2*XLEN+1:0] fastProd;
  logic [XLEN-1:0]          fastRes;

  always_comb begin
    fastA    = {aSigned & op_a[XLEN-1], op_a};
    fastB    = {bSigned & op_b[XLEN-1], op_b};
    fastProd = fastA * fastB;
    fastRes  = (funct3 == F_MUL) ? fastProd[XLEN-1:0] : fastProd[2*XLEN-1:XLEN];
  end
`endif

  // Sequencer: flush beats both a new request and a completing iteration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opd_q      <= '0;
      funct3_q   <= '0;
      rd_q       <= '0;
      neg_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      resultRd_q <= '0;
    end else if (flush) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            funct3_q <= funct3;
            rd_q     <= rd;
            neg_q    <= resNeg_d;
            cnt_q    <= '0;
            if (funct3[2]) begin
              if (divZero || divOvf) begin
                state_q    <= S_DONE;
                done_q     <= 1'b1;
                result_q   <= special_d;
                resultRd_q <= rd;
              end else begin
                state_q <= S_DIV;
                busy_q  <= 1'b1;
                acc_q   <= {{XLEN{1'b0}}, aMag};
                opd_q   <= bMag;
              end
            end else begin
`ifdef KAMACORE_FAST_MUL_EN
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              result_q   <= fastRes;
              resultRd_q <= rd;
`else
              state_q <= S_MUL;
              busy_q  <= 1'b1;
              acc_q   <= {{XLEN{1'b0}}, bMag};
              opd_q   <= aMag;
`endif
            end
          end
        end
        S_MUL, S_DIV: begin
          acc_q <= step_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q    <= S_DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            result_q   <= final_d;
            resultRd_q <= rd_q;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Stall drops in DONE so the EX/MEM buffer captures the result as the pipeline moves on.
  assign stall     = ((state_q == S_IDLE) && start && !flush) || (state_q == S_MUL) || (state_q == S_DIV);
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign result_rd = resultRd_q;

endmodule
